// File: rtl/vga_pkg.sv
// Shared constants and types for the row-buffered VGA pixel block.
package vga_pkg;
  localparam int COLOR_W = 6;
  localparam int ROW_W   = 32;

  localparam logic [1:0] ADDR_ROW  = 2'd0;
  localparam logic [1:0] ADDR_FG   = 2'd1;
  localparam logic [1:0] ADDR_BG   = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [ROW_W-1:0]   row_t;

  localparam color_t FG_RST = 6'h3F;
  localparam color_t BG_RST = 6'h00;

  typedef struct packed {
    logic underrun;
    logic fresh;
  } row_stat_t;

  // colour is {R1,R0,G1,G0,B1,B0}; connector order interleaves syncs
  function automatic logic [7:0] pack_vga(
    input color_t c,
    input logic   vs,
    input logic   hs
  );
    return {c[5], c[3], c[1], vs, c[4], c[2], c[0], hs};
  endfunction
endpackage

// File: rtl/vga_row_buffer.sv
// Pending/active row pair with row-change swap and underrun tracking.
module vga_row_buffer
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_row,
  input  row_t       wr_data,
  input  logic       clr_underrun,
  input  logic [3:0] y_pos,
  output row_t       pending,
  output row_t       active,
  output row_stat_t stat
);
  logic [3:0] y_prev;
  logic       swap;

  assign swap = (y_pos != y_prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= '0;
      active        <= '0;
      stat.fresh    <= 1'b0;
      stat.underrun <= 1'b0;
      y_prev        <= '0;
    end else begin
      y_prev <= y_pos;
      if (swap) begin
        active <= pending;
      end
      if (wr_row) begin
        pending <= wr_data;
      end
      if (wr_row) begin
        stat.fresh <= 1'b1;
      end else if (swap) begin
        stat.fresh <= 1'b0;
      end
      // a fresh underrun outranks a clear issued in the same cycle
      if (swap && !stat.fresh) begin
        stat.underrun <= 1'b1;
      end else if (clr_underrun) begin
        stat.underrun <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/vga_row_pixel.sv
// Register file, per-pixel colour select and registered VGA output.
module vga_row_pixel
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  x_pos,
  input  logic [3:0]  y_pos,
  input  logic        blank,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [7:0]  vga_out
);
  color_t    fg;
  color_t    bg;
  color_t    colour;
  logic      enable;
  row_t      pending;
  row_t      active;
  row_stat_t stat;
  logic      wr_row;
  logic      wr_fg;
  logic      wr_bg;
  logic      wr_ctrl;

  assign wr_row  = wr_en && (wr_addr == ADDR_ROW);
  assign wr_fg   = wr_en && (wr_addr == ADDR_FG);
  assign wr_bg   = wr_en && (wr_addr == ADDR_BG);
  assign wr_ctrl = wr_en && (wr_addr == ADDR_CTRL);

  vga_row_buffer u_buf (
    .clk          (clk),
    .rst          (rst),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .clr_underrun (wr_ctrl && wr_data[1]),
    .y_pos        (y_pos),
    .pending      (pending),
    .active       (active),
    .stat         (stat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fg     <= FG_RST;
      bg     <= BG_RST;
      enable <= 1'b0;
    end else begin
      if (wr_fg) begin
        fg <= wr_data[COLOR_W-1:0];
      end
      if (wr_bg) begin
        bg <= wr_data[COLOR_W-1:0];
      end
      if (wr_ctrl) begin
        enable <= wr_data[0];
      end
    end
  end

  always_comb begin
    colour = '0;
    if (!blank && enable) begin
      colour = active[x_pos] ? fg : bg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out <= 8'h00;
    end else begin
      vga_out <= pack_vga(colour, vsync_in, hsync_in);
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (rd_addr)
      ADDR_ROW:  rd_data = pending;
      ADDR_FG:   rd_data = {26'b0, fg};
      ADDR_BG:   rd_data = {26'b0, bg};
      ADDR_CTRL: rd_data = {28'b0, stat.underrun, stat.fresh, 1'b0, enable};
    endcase
  end
endmodule

// File: tb/tb_vga_row_pixel.sv
// Scoreboard bench for vga_row_pixel with a behavioural row/colour model.
module tb_vga_row_pixel;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  x_pos = '0;
  logic [3:0]  y_pos = '0;
  logic        blank = 1'b1;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic [7:0]  vga_out;

  always #5 clk = ~clk;

  vga_row_pixel dut (
    .clk      (clk),
    .rst      (rst),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .blank    (blank),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .vga_out  (vga_out)
  );

  typedef struct {
    logic [7:0]  vga;
    logic [31:0] rd;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [31:0] m_pend, m_act;
  logic [5:0]  m_fg, m_bg;
  logic        m_fresh, m_under, m_en;
  logic [3:0]  m_yprev;
  logic [3:0]  cy;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic m_reset();
    m_pend = '0; m_act = '0; m_fg = 6'h3F; m_bg = 6'h00;
    m_fresh = 0; m_under = 0; m_en = 0; m_yprev = '0;
  endtask

  // drive one cycle of inputs and queue what the DUT must show after the edge
  task automatic step(input logic r, input logic [4:0] x,
                      input logic [3:0] y, input logic b,
                      input logic hs, input logic vs, input logic we,
                      input logic [1:0] wa, input logic [31:0] wd,
                      input logic [1:0] ra, input string nm);
    exp_t e;
    logic [5:0] c;
    logic swap, old_fresh;
    @(negedge clk);
    rst = r; x_pos = x; y_pos = y; blank = b;
    hsync_in = hs; vsync_in = vs;
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    if (b || !m_en) c = 6'd0;
    else c = m_act[x] ? m_fg : m_bg;
    e.vga = {c[5], c[3], c[1], vs, c[4], c[2], c[0], hs};
    if (r) begin
      e.vga = 8'h00;
      m_reset();
    end else begin
      swap = (y != m_yprev);
      old_fresh = m_fresh;
      if (swap) begin m_act = m_pend; m_fresh = 0; end
      if (we) begin
        case (wa)
          2'd0: begin m_pend = wd; m_fresh = 1; end
          2'd1: m_fg = wd[5:0];
          2'd2: m_bg = wd[5:0];
          default: begin
            m_en = wd[0];
            if (wd[1]) m_under = 0;
          end
        endcase
      end
      if (swap && !old_fresh) m_under = 1;
      m_yprev = y;
    end
    case (ra)
      2'd0: e.rd = m_pend;
      2'd1: e.rd = {26'b0, m_fg};
      2'd2: e.rd = {26'b0, m_bg};
      default: e.rd = {28'b0, m_under, m_fresh, 1'b0, m_en};
    endcase
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, "_vga"}, {24'b0, vga_out}, {24'b0, e.vga});
      chk({e.name, "_rd"}, rd_data, e.rd);
    end
  end

  initial begin
    m_reset();
    cy = 0;
    step(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, "rst0");
    step(1, 0, 0, 1, 1, 1, 1, 0, 32'h1234, 3, "rst1");
    after_edge();
    chk("reset_vga", {24'b0, vga_out}, 32'h0);
    chk("reset_ctrl", rd_data, 32'h0);

    step(0, 0, cy, 1, 1, 1, 1, 3, 32'h1, 3, "en");
    step(0, 0, cy, 1, 1, 1, 1, 0, 32'h1, 0, "row1");
    step(0, 0, cy, 1, 1, 1, 1, 1, 32'h30, 1, "fg30");
    cy = 1;
    step(0, 0, cy, 0, 1, 1, 0, 0, 0, 0, "swap1");
    step(0, 0, cy, 0, 1, 1, 0, 0, 0, 0, "px0");
    after_edge();
    chk("red_pixel", {24'b0, vga_out}, 32'h99);

    cy = 2;
    step(0, 0, cy, 1, 1, 1, 0, 0, 0, 3, "swap2");
    after_edge();
    chk("underrun_set", rd_data, 32'h9);
    step(0, 0, cy, 1, 1, 1, 1, 3, 32'h3, 3, "clr");
    after_edge();
    chk("underrun_clr", rd_data, 32'h1);

    step(0, 0, cy, 1, 1, 1, 1, 0, 32'h5555_5555, 0, "row55");
    cy = 3;
    step(0, 0, cy, 1, 1, 1, 1, 0, 32'hAAAA_AAAA, 0, "rowaa_swap");
    after_edge();
    chk("same_cycle_pend", rd_data, 32'hAAAA_AAAA);
    step(0, 0, cy, 0, 1, 1, 0, 0, 0, 3, "px55_0");
    after_edge();
    chk("same_cycle_act", {24'b0, vga_out}, 32'h99);
    chk("same_cycle_ctrl", rd_data, 32'h5);
    step(0, 1, cy, 0, 1, 1, 0, 0, 0, 0, "px55_1");
    after_edge();
    chk("bg_pixel", {24'b0, vga_out}, 32'h11);

    step(0, 0, cy, 1, 1, 1, 1, 0, 32'hFFFF_FFFF, 0, "rowff");
    cy = 4;
    step(0, 0, cy, 1, 1, 1, 0, 0, 0, 0, "swapff");
    step(0, 7, cy, 1, 0, 1, 0, 0, 0, 0, "blank");
    after_edge();
    chk("blank_hs", {24'b0, vga_out}, 32'h10);

    step(0, 0, cy, 0, 1, 1, 1, 3, 32'h0, 0, "dis");
    step(0, 0, cy, 0, 1, 0, 0, 0, 0, 0, "dis_vs");
    after_edge();
    chk("dis_vs", {24'b0, vga_out}, 32'h01);
    step(0, 0, cy, 0, 0, 1, 0, 0, 0, 0, "dis_hs");
    after_edge();
    chk("dis_hs", {24'b0, vga_out}, 32'h10);

    step(0, 0, cy, 0, 1, 1, 1, 1, 32'h0C, 0, "fg0c");
    step(0, 0, cy, 0, 1, 1, 1, 0, 32'h1234, 0, "row1234");
    step(1, 3, cy, 0, 1, 1, 1, 0, 32'hDEAD, 1, "rst_mid");
    after_edge();
    chk("rst_mid_vga", {24'b0, vga_out}, 32'h0);
    chk("rst_mid_fg", rd_data, 32'h3F);
    cy = 0;
    step(0, 0, cy, 1, 1, 1, 0, 0, 0, 0, "post_rst_row");
    after_edge();
    chk("post_rst_row", rd_data, 32'h0);
    step(0, 0, cy, 1, 1, 1, 0, 0, 0, 3, "post_rst_ctrl");
    after_edge();
    chk("post_rst_ctrl", rd_data, 32'h0);
    cy = 1;
    step(0, 0, cy, 1, 1, 1, 0, 0, 0, 3, "post_rst_swap");
    after_edge();
    chk("post_rst_under", rd_data, 32'h8);

    for (int i = 0; i < 400; i++) begin
      logic r, we, b;
      r = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 5) == 0) cy = 4'($urandom);
      we = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 3) == 0);
      step(r, 5'($urandom), cy, b, 1'($urandom), 1'($urandom), we,
           2'($urandom), $urandom, 2'($urandom), "rand");
    end

    repeat (3) @(posedge clk);
    #2;
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
